// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between the millisecond timer
// (master) and the sequential binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift-and-adjust
// step per clock. The previous result stays on bcd/overflow until the
// new conversion completes, so the display never shows a partial value.
//
// Optional build macro BIN2BCD_CLAMP_EN: when defined, an overflowing
// result is shown as all nines instead of its low DIGITS digits.
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input logic            clk,
    input logic            reset,
    bin2bcd_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               last_step;

    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   shift_q;
    logic [SCR_W-1:0]   scratch_q;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_nxt;
    logic [WIDTH-1:0]   shift_nxt;
    logic               ovf_nxt;

    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               done_q;

    // Double-dabble correction for one BCD nibble.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

`ifdef BIN2BCD_CLAMP_EN
    // Saturate the displayed value at all nines when the result does not fit.
    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] low,
                                                   input logic             ovf);
        return ovf ? {DIGITS{4'h9}} : low;
    endfunction
`endif

    // One conversion step: adjust every nibble in parallel, then shift left.
    always_comb begin
        scratch_adj = '0;
        for (int i = 0; i < DIGITS + 1; i++) begin
            scratch_adj[4*i +: 4] = add3(scratch_q[4*i +: 4]);
        end
        scratch_nxt = {scratch_adj[SCR_W-2:0], shift_q[WIDTH-1]};
        shift_nxt   = {shift_q[WIDTH-2:0], 1'b0};
        // A bit leaving the scratch register would equally mean the value
        // did not fit; in the supported input range it is always zero.
        ovf_nxt     = (|scratch_nxt[SCR_W-1:BCD_W]) | scratch_adj[SCR_W-1];
    end

    // Next-state logic: accept a request in IDLE, return after the last shift.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    last_step = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers: load on accept, step once per cycle while shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
        end else if (accept) begin
            cnt_q     <= CNT_W'(WIDTH);
            shift_q   <= bus.bin;
            scratch_q <= '0;
        end else if (state_q == SHIFT) begin
            cnt_q     <= cnt_q - CNT_W'(1);
            shift_q   <= shift_nxt;
            scratch_q <= scratch_nxt;
        end
    end

    // Result registers: updated only on the final shift, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_step;
            if (last_step) begin
                ovf_q <= ovf_nxt;
`ifdef BIN2BCD_CLAMP_EN
                bcd_q <= clamp_bcd(scratch_nxt[BCD_W-1:0], ovf_nxt);
`else
                bcd_q <= scratch_nxt[BCD_W-1:0];
`endif
            end
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule
